// File: rtl/ram16_arb.sv
// rtl/ram16_arb.sv - two-requester arbiter/sequencer serialising reads and writes onto one 16x8 RAM port
// Define RAM16_ARB_FIXED_PRIO_EN to make requester 0 win every tie instead of alternating.
module ram16_arb #(
  parameter int Width  = 16,
  parameter int ADD_WD = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADD_WD-1:0] addr0,
  input  logic [Width-1:0]  wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADD_WD-1:0] addr1,
  input  logic [Width-1:0]  wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [Width-1:0]  rdata,
  output logic              busy,
  output logic              ram_wr_en,
  output logic              ram_rd_en,
  output logic [ADD_WD-1:0] ram_addr,
  output logic [Width-1:0]  ram_wdata,
  input  logic [Width-1:0]  ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  // last_gnt_q doubles as the owner of the in-flight read.
  logic                last_gnt_q, last_gnt_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic                busy_q, busy_d;
  logic                wr_en_q, wr_en_d;
  logic                rd_en_q, rd_en_d;
  logic [ADD_WD-1:0]   addr_q, addr_d;
  logic [Width-1:0]    wdata_q, wdata_d;
  logic [Width-1:0]    rdata_q, rdata_d;

  logic                any_req;
  logic                sel1;
  logic                sel_we;
  logic [ADD_WD-1:0]   sel_addr;
  logic [Width-1:0]    sel_wdata;

  always_comb begin
    any_req = req0 | req1;
`ifdef RAM16_ARB_FIXED_PRIO_EN
    sel1 = req1 & ~req0;
`else
    sel1 = req1 & (~req0 | ~last_gnt_q);
`endif
    sel_we    = sel1 ? we1    : we0;
    sel_addr  = sel1 ? addr1  : addr0;
    sel_wdata = sel1 ? wdata1 : wdata0;
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    rvalid0_d  = 1'b0;
    rvalid1_d  = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d    = ISSUE;
          last_gnt_d = sel1;
          gnt0_d     = ~sel1;
          gnt1_d     = sel1;
          addr_d     = sel_addr;
          wdata_d    = sel_wdata;
          wr_en_d    = sel_we;
          rd_en_d    = ~sel_we;
        end
      end
      ISSUE: begin
        // rd_en_q is still high here exactly when the issued command is a read.
        state_d = rd_en_q ? RDWAIT : IDLE;
      end
      RDWAIT: begin
        rdata_d   = ram_rdata;
        rvalid0_d = ~last_gnt_q;
        rvalid1_d = last_gnt_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      last_gnt_q <= 1'b1;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign rvalid0   = rvalid0_q;
  assign rvalid1   = rvalid1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign ram_wr_en = wr_en_q;
  assign ram_rd_en = rd_en_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

endmodule
